// File: rtl/sipo_receiver.sv
// LSB-first serial-to-parallel receiver framed by the transmitter's SL strobe.
// Completed words go to a one-deep valid/ready output slot; framing errors and overruns pulse.
module sipo_receiver #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             SL,
  input  logic             serial_in,
  input  logic             data_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_next;
  logic [CW-1:0]    cnt, cnt_next;
  logic [WIDTH-1:0] shreg, shreg_next;
  logic [WIDTH-1:0] new_word;
  logic [WIDTH-1:0] data_out_next;
  logic             data_valid_next;
  logic             frame_err_next;
  logic             overrun_next;
  logic             complete;

  assign new_word = {serial_in, shreg[WIDTH-1:1]};
  // busy comes straight from the state register and doubles as the FSM debug view.
  assign busy     = (state == SHIFT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      shreg <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      shreg <= shreg_next;
    end
  end

  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    shreg_next     = shreg;
    frame_err_next = 1'b0;
    complete       = 1'b0;
    case (state)
      IDLE: begin
        if (SL) begin
          state_next = SHIFT;
          cnt_next   = '0;
        end
      end
      SHIFT: begin
        if (cnt == LAST) begin
          // Final bit: a coincident SL is a gapless next word, not an error.
          complete   = 1'b1;
          shreg_next = new_word;
          cnt_next   = '0;
          state_next = SL ? SHIFT : IDLE;
        end else if (SL) begin
          frame_err_next = 1'b1;
          cnt_next       = '0;
          shreg_next     = '0;
        end else begin
          shreg_next = new_word;
          cnt_next   = cnt + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Output handshake: a word transfers on any rising edge where data_valid and
  // data_ready are both high; data_valid stays high until that edge and
  // data_out is stable while data_valid is high.
  always_comb begin
    data_out_next   = data_out;
    data_valid_next = data_valid;
    overrun_next    = 1'b0;
    if (complete) begin
      if (!data_valid || data_ready) begin
        data_out_next   = new_word;
        data_valid_next = 1'b1;
      end else begin
        overrun_next = 1'b1;
      end
    end else if (data_valid && data_ready) begin
      data_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      data_out   <= data_out_next;
      data_valid <= data_valid_next;
      frame_err  <= frame_err_next;
      overrun    <= overrun_next;
    end
  end

endmodule
